// File: rtl/div_freq_meter.sv
// div_freq_meter: gated frequency meter for a divided clock.
// Counts synchronised rising edges of sig_in over a window of gate_len clk
// cycles and reports the result in count with a one-cycle done strobe.
// Optional macro FREQ_METER_AUTO_EN: free-running mode, DONE reloads the
// latched window length and starts the next window immediately.

module div_freq_meter #(
    parameter int unsigned GATE_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              sig_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic              s1;
    logic              s2;
    logic              s3;
    logic              sig_edge_c;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [GATE_W-1:0] gate_cnt_d;
    logic [CNT_W-1:0]  count_d;
    logic              ovf_d;
    logic              busy_d;
    logic              done_d;
`ifdef FREQ_METER_AUTO_EN
    logic [GATE_W-1:0] gate_len_q;
    logic [GATE_W-1:0] gate_len_d;
`endif

    // Synchronise sig_in and keep one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge_c = s2 & ~s3;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef FREQ_METER_AUTO_EN
            gate_len_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            count      <= count_d;
            ovf        <= ovf_d;
            busy       <= busy_d;
            done       <= done_d;
`ifdef FREQ_METER_AUTO_EN
            gate_len_q <= gate_len_d;
`endif
        end
    end

    // Next-state and next-output decode; done is asserted on entry to DONE
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        count_d    = count;
        ovf_d      = ovf;
        busy_d     = busy;
        done_d     = 1'b0;
`ifdef FREQ_METER_AUTO_EN
        gate_len_d = gate_len_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gate_cnt_d = gate_len;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    busy_d     = 1'b1;
`ifdef FREQ_METER_AUTO_EN
                    gate_len_d = gate_len;
`endif
                    if (gate_len == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (sig_edge_c) begin
                    if (count == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count + CNT_W'(1);
                    end
                end
                gate_cnt_d = gate_cnt_q - GATE_W'(1);
                if (gate_cnt_q == GATE_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
`ifdef FREQ_METER_AUTO_EN
                gate_cnt_d = gate_len_q;
                count_d    = '0;
                ovf_d      = 1'b0;
                if (gate_len_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_GATE;
                end
`else
                state_d = ST_IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_div_freq_meter.sv
// Self-checking bench for div_freq_meter. Two instances share stimulus: a
// full-width one and a 4-bit counter one for saturation. Expected counts come
// from a record of the sig_in level seen at each clk edge: an edge counted at
// posedge j is a low-to-high step between the levels sampled at j-3 and j-2.

module tb_div_freq_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] gate_len;
    logic        sig_in;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic        ovf;
    logic        busy_s;
    logic        done_s;
    logic [3:0]  count_s;
    logic        ovf_s;

    int n_chk  = 0;
    int n_pass = 0;

    int pcount = 0;
    bit samp [0:16383];

    int mode = 0;
    int per  = 2;
    int ph   = 0;
    bit lvl  = 1'b0;

    longint exp16;
    longint exp4;

    div_freq_meter #(.GATE_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .sig_in(sig_in),
        .busy(busy), .done(done), .count(count), .ovf(ovf)
    );

    div_freq_meter #(.GATE_W(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .sig_in(sig_in),
        .busy(busy_s), .done(done_s), .count(count_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    // Level of sig_in as seen by the meter at every posedge (zero under reset)
    always @(posedge clk) begin
        samp[pcount] = rst ? sig_in : 1'b0;
        pcount++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance to the next negedge and drive the next sig_in value
    task automatic tick();
        @(negedge clk);
        case (mode)
            0: sig_in = lvl;
            1: begin
                sig_in = ((ph % per) < (per / 2));
                ph++;
            end
            default: sig_in = 1'($urandom_range(0, 1));
        endcase
    endtask

    function automatic int raw_edges(input int t0, input int n);
        int c = 0;
        for (int j = t0 + 1; j <= t0 + n; j++)
            if (samp[j-2] && !samp[j-3]) c++;
        return c;
    endfunction

    function automatic void set_exp(input int raw);
        exp16 = (raw > 65535) ? 65535 : raw;
        exp4  = (raw > 15) ? 15 : raw;
    endfunction

    // One single-shot window of n cycles; optional re-pulse of start at index restart_at
    task automatic measure(input int n, input int restart_at);
        int t0;
        int raw;
        tick();
        start    = 1'b1;
        gate_len = 16'(n);
        t0       = pcount;
        tick();
        start    = 1'b0;
        gate_len = 16'($urandom);
        for (int k = 0; k <= n + 1; k++) begin
            if (k > 0) begin
                tick();
                start = (k == restart_at);
            end
            check("done", longint'(done), longint'(k == n));
            check("busy", longint'(busy), longint'(k <= n));
            if (k == n) begin
                raw = raw_edges(t0, n);
                set_exp(raw);
                check("count", longint'(count), exp16);
                check("ovf", longint'(ovf), longint'(raw > 65535));
                check("count_small", longint'(count_s), exp4);
                check("ovf_small", longint'(ovf_s), longint'(raw > 15));
            end
            if (k == n + 1) check("count_hold", longint'(count), exp16);
        end
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        gate_len = '0;
        sig_in   = 1'b0;
        repeat (4) tick();
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_count", longint'(count), 0);
        check("rst_ovf", longint'(ovf), 0);
        rst = 1'b1;
        repeat (4) tick();

`ifdef FREQ_METER_AUTO_EN
        begin
            int t0;
            mode = 1; per = 2; ph = 0;
            repeat (4) tick();
            tick();
            start    = 1'b1;
            gate_len = 16'd20;
            t0       = pcount;
            tick();
            start = 1'b0;
            for (int w = 0; w < 4; w++) begin
                for (int k = 0; k <= 20; k++) begin
                    if (!(w == 0 && k == 0)) tick();
                    check("auto_busy", longint'(busy), 1);
                    check("auto_done", longint'(done), longint'(k == 20));
                    if (k == 20) begin
                        set_exp(raw_edges(t0, 20));
                        check("auto_count", longint'(count), exp16);
                        check("auto_range", longint'(count >= 10 && count <= 11), 1);
                    end
                end
                t0 = t0 + 21;
            end
        end
`else
        // divide-by-2, 100-cycle window; then a 10-cycle window clears ovf
        mode = 1; per = 2; ph = 0;
        repeat (4) tick();
        measure(100, -1);
        check("d2_count", longint'(count), 50);
        check("d2_small_sat", longint'(count_s), 15);
        check("d2_small_ovf", longint'(ovf_s), 1);
        measure(10, -1);
        check("d2_10_small", longint'(count_s), 5);
        check("d2_10_ovf", longint'(ovf_s), 0);

        // divide-by-4
        per = 4; ph = 0;
        repeat (4) tick();
        measure(100, -1);
        check("d4_count", longint'(count), 25);
        measure(7, -1);
        check("d4_7_range", longint'(count == 1 || count == 2), 1);

        // zero window, then ignored start inside a 20-cycle window
        measure(0, -1);
        check("zero_count", longint'(count), 0);
        measure(20, 3);

        // random periods, phases and noise
        for (int r = 0; r < 10; r++) begin
            mode = $urandom_range(1, 2);
            per  = 2 * $urandom_range(1, 5);
            ph   = $urandom_range(0, 1000);
            repeat ($urandom_range(3, 6)) tick();
            measure($urandom_range(1, 60), -1);
        end

        // reset in the middle of a window, sig_in held high across release
        mode = 1; per = 2; ph = 0;
        repeat (4) tick();
        tick();
        start    = 1'b1;
        gate_len = 16'd100;
        tick();
        start = 1'b0;
        repeat (39) tick();
        rst  = 1'b0;
        mode = 0;
        lvl  = 1'b1;
        #1;
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_count", longint'(count), 0);
        check("mid_rst_done", longint'(done), 0);
        check("mid_rst_ovf", longint'(ovf), 0);
        repeat (3) tick();
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("post_rst_busy", longint'(busy), 0);
            check("post_rst_count", longint'(count), 0);
        end
        measure(30, -1);
        check("high_level_count", longint'(count), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
